multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
// Multicycle control unit directly upstream of the ALU. Decodes the instruction held in IR.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the ALU's 3-bit control code
// and operand selects. Consumes the ALU's comp flag to resolve branches.
// Owns the memory request handshake, with a bounded wait timeout.
// PARAMETERS
// MEM_TIMEOUT  16  max cycles a memory request may wait for mem_ready before trapping (>=2)
// TIMEOUT_EN   1   1: timeout check active; 0: wait indefinitely
// PORTS
// clk          in   1   single clock, rising edge
// rst          in   1   asynchronous, active-high reset
// instr        in   32  IR contents (valid from DECODE onward)
// comp         in   1   ALU comparison result
// mem_ready    in   1   memory done: fetch/load data valid, or store accepted
// alu_control  out  3   000 add, 001 sll, 010 and, 011 A!=0, 100 A>=B, 101 pass B
// alu_src_a    out  2   00 PC, 01 oldPC, 10 rs1
// alu_src_b    out  2   00 rs2, 01 imm, 10 const 4
// imm_sel      out  2   00 I-type, 01 S-type, 10 B-type, 11 U-type
// result_src   out  2   00 ALUOut reg, 01 mem read data, 10 ALU result (direct)
// pc_src       out  1   0 ALU result, 1 ALUOut (branch target)
// pc_write, ir_write, reg_write, mem_read, mem_write, adr_src  out  1 each (adr_src: 0 PC, 1 ALUOut)
// illegal      out  1   sticky: unsupported instruction decoded
// timeout      out  1   sticky: memory wait exceeded MEM_TIMEOUT
// state        out  4   current state encoding, for debug
// BEHAVIOUR
// - Reset (async): state=FETCH, wait counter=0, illegal=0, timeout=0.
//   While rst=1 every strobe output is 0. All other outputs decode from state (Moore).
//   Exceptions: pc_write, ir_write, and next-state.
// - FETCH: mem_read=1, adr_src=0, srcA=00, srcB=10, alu=000.
//   If mem_ready: ir_write=1, pc_write=1, pc_src=0, go DECODE. Else stay.
// - DECODE: srcA=01, srcB=01, imm_sel=10, alu=000 (branch target into ALUOut). Dispatch on opcode/funct:
//   0110011 f7=0 f3 000/001/111 -> EXEC_R (add/sll/and)
//   0010011 f3 000/111; f3 001 with f7=0 -> EXEC_I (addi/andi/slli)
//   0000011 f3=010 (lw) / 0100011 f3=010 (sw) -> MEM_ADDR
//   1100011: f3=101 (bge), or f3=001 (bne) with rs2=x0 -> BRANCH
//   0110111 -> EXEC_LUI
//   anything else -> TRAP, illegal<=1
// - EXEC_R: srcA=10, srcB=00, alu from f3 (000->000, 001->001, 111->010), go WB_ALU.
// - EXEC_I: same with srcB=01, imm_sel=00, go WB_ALU.
// - EXEC_LUI: srcB=01, imm_sel=11, alu=101, go WB_ALU.
// - WB_ALU: reg_write=1, result_src=00, go FETCH.
// - MEM_ADDR: srcA=10, srcB=01, imm_sel 00 (lw) / 01 (sw), alu=000.
//   Go MEM_RD (lw) or MEM_WR (sw).
// - MEM_RD: mem_read=1, adr_src=1. On mem_ready go WB_MEM.
//   WB_MEM: reg_write=1, result_src=01, go FETCH.
// - MEM_WR: mem_write=1, adr_src=1. On mem_ready go FETCH.
// - BRANCH: srcA=10, srcB=00, alu=100 (bge) or 011 (bne). pc_src=1, pc_write=comp. Go FETCH.
// - Latency in cycles, with zero memory wait: R/I/LUI 4, lw 5, sw 4, branch 3.
//   Each cycle without mem_ready in FETCH/MEM_RD/MEM_WR adds 1.
// - Wait counter: cleared on entry to any memory state; increments each cycle mem_ready=0.
//   If TIMEOUT_EN and counter reaches MEM_TIMEOUT with mem_ready still 0: go TRAP, timeout<=1.
//   If mem_ready arrives in the same cycle the counter hits the limit, mem_ready wins.
// - TRAP: all strobes 0; held until rst. illegal/timeout are never cleared except by rst.
// - Reset mid-operation (e.g. in MEM_RD): strobes drop immediately (async); FETCH on release.
//   No partial register or PC write occurs.
// TESTING
// - addi x1,x0,5 (0x00500093), mem_ready=1 each fetch
//   -> states FETCH,DECODE,EXEC_I,WB_ALU; alu=000, srcB=01, reg_write=1 only in WB_ALU.
// - lw (0x0000A103), mem_ready low 3 cycles in MEM_RD
//   -> stays MEM_RD 4 cycles with mem_read=1, then WB_MEM result_src=01; 8 cycles total.
// - bge with comp=1 -> BRANCH alu=100, pc_write=1, pc_src=1.
//   bne rs2=x0 with comp=0 -> alu=011, pc_write=0.
// - Opcode 0x7F, or bne with rs2=x5 -> TRAP, illegal=1, strobes 0 until rst.
// - TIMEOUT_EN=1, MEM_TIMEOUT=16, mem_ready stuck 0 in FETCH
//   -> TRAP after 16 cycles, timeout=1; rst clears it and resumes FETCH.
// - rst asserted mid-MEM_WR -> mem_write drops same cycle; state=FETCH, no pc_write.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for a small RV32 subset: sequences fetch/decode/execute/memory/writeback,
// drives ALU control and operand selects, and bounds every memory wait with a timeout trap.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          TIMEOUT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        comp,
  input  logic        mem_ready,
  output logic [2:0]  alu_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_sel,
  output logic [1:0]  result_src,
  output logic        pc_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        adr_src,
  output logic        illegal,
  output logic        timeout,
  output logic [3:0]  state
);

  localparam int unsigned      CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_LUI = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           state_q, state_d, decode_target;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             pc_write_c, ir_write_c;
  logic             mem_wait;

  logic [2:0] alu_control_q, alu_control_d;
  logic [1:0] alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [1:0] imm_sel_q, imm_sel_d;
  logic [1:0] result_src_q, result_src_d;
  logic       pc_src_q, pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       adr_src_q, adr_src_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs2;
  logic       is_store;
  logic [2:0] alu_from_f3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7            = instr[31:25];
  assign rs2               = instr[24:20];
  assign is_store          = (opcode == OP_STORE);
  assign unused_instr_bits = ^{instr[19:15], instr[11:7]};

  // R/I-type ALU op from funct3: add, sll, and
  always_comb begin
    alu_from_f3 = 3'b000;
    case (funct3)
      3'b001:  alu_from_f3 = 3'b001;
      3'b111:  alu_from_f3 = 3'b010;
      default: alu_from_f3 = 3'b000;
    endcase
  end

  // Opcode/funct dispatch out of DECODE; anything unsupported traps
  always_comb begin
    decode_target = S_TRAP;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'd0 && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b111))
          decode_target = S_EXEC_R;
      end
      OP_IMM: begin
        if (funct3 == 3'b000 || funct3 == 3'b111 || (funct3 == 3'b001 && funct7 == 7'd0))
          decode_target = S_EXEC_I;
      end
      OP_LOAD, OP_STORE: begin
        if (funct3 == 3'b010) decode_target = S_MEM_ADDR;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b101 || (funct3 == 3'b001 && rs2 == 5'd0)) decode_target = S_BRANCH;
      end
      OP_LUI:  decode_target = S_EXEC_LUI;
      default: decode_target = S_TRAP;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    pc_write_c = 1'b0;
    ir_write_c = 1'b0;
    mem_wait   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        state_d = decode_target;
        if (decode_target == S_TRAP) illegal_d = 1'b1;
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_d = S_WB_ALU;
      S_WB_ALU, S_WB_MEM:             state_d = S_FETCH;
      S_MEM_ADDR: state_d = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
        else           mem_wait = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
        else           mem_wait = 1'b1;
      end
      S_BRANCH: begin
        pc_write_c = comp;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // A ready in the limit cycle never reaches this path, so mem_ready wins the tie
    if (mem_wait) begin
      if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
        state_d   = S_TRAP;
        timeout_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if ((state_d == S_FETCH || state_d == S_MEM_RD || state_d == S_MEM_WR) && state_d != state_q)
      cnt_d = '0;
  end

  // Moore outputs for the state being entered, so they come straight from flops
  always_comb begin
    alu_control_d = 3'b000;
    alu_src_a_d   = 2'b00;
    alu_src_b_d   = 2'b00;
    imm_sel_d     = 2'b00;
    result_src_d  = 2'b00;
    pc_src_d      = 1'b0;
    reg_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    adr_src_d     = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
        imm_sel_d   = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = alu_from_f3;
      end
      S_EXEC_I: begin
        alu_src_a_d   = 2'b10;
        alu_src_b_d   = 2'b01;
        alu_control_d = alu_from_f3;
      end
      S_EXEC_LUI: begin
        alu_src_b_d   = 2'b01;
        imm_sel_d     = 2'b11;
        alu_control_d = 3'b101;
      end
      S_WB_ALU: reg_write_d = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        imm_sel_d   = is_store ? 2'b01 : 2'b00;
      end
      S_MEM_RD: begin
        mem_read_d = 1'b1;
        adr_src_d  = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
      end
      S_MEM_WR: begin
        mem_write_d = 1'b1;
        adr_src_d   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = (funct3 == 3'b101) ? 3'b100 : 3'b011;
        pc_src_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      cnt_q         <= '0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      // Reset values equal the FETCH decode
      alu_control_q <= 3'b000;
      alu_src_a_q   <= 2'b00;
      alu_src_b_q   <= 2'b10;
      imm_sel_q     <= 2'b00;
      result_src_q  <= 2'b00;
      pc_src_q      <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b1;
      mem_write_q   <= 1'b0;
      adr_src_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      alu_control_q <= alu_control_d;
      alu_src_a_q   <= alu_src_a_d;
      alu_src_b_q   <= alu_src_b_d;
      imm_sel_q     <= imm_sel_d;
      result_src_q  <= result_src_d;
      pc_src_q      <= pc_src_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      adr_src_q     <= adr_src_d;
    end
  end

  // Strobes are masked by rst directly so they drop the moment reset asserts
  assign pc_write    = pc_write_c & ~rst;
  assign ir_write    = ir_write_c & ~rst;
  assign reg_write   = reg_write_q & ~rst;
  assign mem_read    = mem_read_q & ~rst;
  assign mem_write   = mem_write_q & ~rst;
  assign alu_control = alu_control_q;
  assign alu_src_a   = alu_src_a_q;
  assign alu_src_b   = alu_src_b_q;
  assign imm_sel     = imm_sel_q;
  assign result_src  = result_src_q;
  assign pc_src      = pc_src_q;
  assign adr_src     = adr_src_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign state       = state_q;

endmodule
